// File: rtl/seq_stage_controller.sv
// seq_stage_controller
// Multi-cycle sequencer for the Y86-64 SEQ datapath. Each instruction steps
// through FETCH, DECODE, EXECUTE, optional MEMORY, WRITEBACK and PCUPD as
// separate clock states. The block owns every state-changing strobe in the
// processor and folds fetch/memory faults into the architectural status code.
//
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   start                   begin execution (IDLE only)
//   icode, instr_valid,     fetch-unit results
//   imem_error
//   cnd                     execute-unit condition, latched in EXECUTE
//   mem_ready, dmem_error   data-memory handshake response
//   state                   current state encoding
//   fetch_en/decode_en/     one-cycle stage enables
//   execute_en
//   mem_req, mem_wr         data-memory request (held) and direction
//   cc_we, rf_we_e, rf_we_m condition-code and register-file strobes
//   pc_we                   PC update strobe
//   stat, halted            1=AOK 2=HLT 3=ADR 4=INS; HALT-state flag
//   retired, cycles         instruction and active-cycle counters (wrap)
module seq_stage_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             cnd,
  input  logic             mem_ready,
  input  logic             dmem_error,
  output logic [2:0]       state,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             cc_we,
  output logic             rf_we_e,
  output logic             rf_we_m,
  output logic             pc_we,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t             state_q, state_d;
  logic [3:0]         ir_icode;
  logic               cnd_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [2:0]         stat_q;
  logic [CNT_W-1:0]   retired_q, cycles_q;

  // Instruction classes, all taken from the latched icode so no output
  // depends combinationally on the fetch-unit inputs.
  logic uses_mem, mem_is_wr, writes_e, writes_m, fetch_fault, fetch_halt;
  logic wait_at_limit;

  assign uses_mem  = ir_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign mem_is_wr = ir_icode inside {4'h4, 4'h8, 4'hA};
  assign writes_e  = (ir_icode inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ||
                     (ir_icode == 4'h2 && cnd_q);
  assign writes_m  = ir_icode inside {4'h5, 4'hB};

  assign fetch_fault   = imem_error || !instr_valid;
  assign fetch_halt    = !fetch_fault && (icode == 4'h0);
  assign wait_at_limit = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     state_d = (fetch_fault || fetch_halt) ? S_HALT : S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = uses_mem ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        // A response in the last allowed cycle beats the timeout.
        if (mem_ready)          state_d = dmem_error ? S_HALT : S_WRITEBACK;
        else if (wait_at_limit) state_d = S_HALT;
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    cc_we      = 1'b0;
    rf_we_e    = 1'b0;
    rf_we_m    = 1'b0;
    pc_we      = 1'b0;
    case (state_q)
      S_FETCH:   fetch_en = 1'b1;
      S_DECODE:  decode_en = 1'b1;
      S_EXECUTE: begin
        execute_en = 1'b1;
        cc_we      = (ir_icode == 4'h6);
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_wr  = mem_is_wr;
      end
      S_WRITEBACK: begin
        rf_we_e = writes_e;
        rf_we_m = writes_m;
      end
      S_PCUPD:   pc_we = 1'b1;
      default:   ;
    endcase
  end

  // Instruction register, condition latch, memory wait counter, status and
  // counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_icode  <= 4'h0;
      cnd_q     <= 1'b0;
      wait_cnt  <= '0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (state_q inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD})
        cycles_q <= cycles_q + CNT_W'(1);
      case (state_q)
        S_IDLE: if (start) stat_q <= STAT_AOK;
        S_FETCH: begin
          if (imem_error)          stat_q <= STAT_ADR;
          else if (!instr_valid)   stat_q <= STAT_INS;
          else if (icode == 4'h0) begin
            stat_q    <= STAT_HLT;
            retired_q <= retired_q + CNT_W'(1);
          end else                 ir_icode <= icode;
        end
        S_EXECUTE: begin
          cnd_q    <= cnd;
          wait_cnt <= '0;  // the only way into MEMORY is from here
        end
        S_MEMORY: begin
          if (mem_ready) begin
            if (dmem_error) stat_q <= STAT_ADR;
          end else if (wait_at_limit) begin
            stat_q <= STAT_ADR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_PCUPD: retired_q <= retired_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign stat    = stat_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller: a table of instruction
// vectors with hand-derived strobe expectations, scoreboarded per
// instruction, plus hand-written sequences for timeout, fetch faults and
// reset during a memory wait.
module tb_seq_stage_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic        instr_valid, imem_error, cnd, mem_ready, dmem_error;
  logic [2:0]  state;
  logic        fetch_en, decode_en, execute_en, mem_req, mem_wr;
  logic        cc_we, rf_we_e, rf_we_m, pc_we;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] retired, cycles;

  seq_stage_controller #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
    .mem_ready(mem_ready), .dmem_error(dmem_error), .state(state),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .mem_req(mem_req), .mem_wr(mem_wr), .cc_we(cc_we), .rf_we_e(rf_we_e),
    .rf_we_m(rf_we_m), .pc_we(pc_we), .stat(stat), .halted(halted),
    .retired(retired), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] icode;
    logic       cnd;
    int         nready;   // MEMORY cycles with mem_ready low before it rises
    logic       rf_e;
    logic       rf_m;
    logic       cc;
    logic       wr;
    logic       mem;
  } vec_t;

  typedef struct {
    int cyc, fe, de, ee, memq, wrq, cc, rfe, rfm, pcw, bad;
  } tally_t;

  int     n_vec = 0;
  int     n_bad = 0;
  int     retired_m = 0;
  int     cycles_m  = 0;
  tally_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; icode = 4'h0; instr_valid = 1'b0;
    imem_error = 1'b0; cnd = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    retired_m = 0;
    cycles_m  = 0;
    @(negedge clk);
  endtask

  task automatic go_fetch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_to_fetch", state, 3'd1);
  endtask

  // Runs one instruction starting at a negedge where state is FETCH and ends
  // at the negedge of the following FETCH. icode/cnd carry the real value
  // only in FETCH/EXECUTE so the DUT must use its latched copies.
  task automatic run_instr(input vec_t v, input string tag);
    tally_t o, e;
    int     mem_k = 0;
    bit     done  = 0;
    e = '{cyc: 5 + (v.mem ? v.nready + 1 : 0), fe: 1, de: 1, ee: 1,
          memq: v.mem ? v.nready + 1 : 0, wrq: v.wr ? v.nready + 1 : 0,
          cc: int'(v.cc), rfe: int'(v.rf_e), rfm: int'(v.rf_m), pcw: 1, bad: 0};
    sb.push_back(e);
    o = '{default: 0};
    instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      o.cyc++;
      o.fe   += int'(fetch_en);
      o.de   += int'(decode_en);
      o.ee   += int'(execute_en);
      o.memq += int'(mem_req);
      o.wrq  += int'(mem_wr);
      o.cc   += int'(cc_we);
      o.rfe  += int'(rf_we_e);
      o.rfm  += int'(rf_we_m);
      o.pcw  += int'(pc_we);
      if ((fetch_en && state != 3'd1) || (decode_en && state != 3'd2) ||
          (execute_en && state != 3'd3) || (cc_we && state != 3'd3) ||
          (mem_req && state != 3'd4) || (mem_wr && !mem_req) ||
          ((rf_we_e || rf_we_m) && state != 3'd5) || (pc_we && state != 3'd6))
        o.bad++;
      icode = (state == 3'd1) ? v.icode : ~v.icode;
      cnd   = (state == 3'd3) ? v.cnd : ~v.cnd;
      if (state == 3'd4) begin
        mem_ready = (mem_k == v.nready);
        mem_k++;
      end else begin
        mem_ready = 1'b0;
      end
      if (pc_we) done = 1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check({tag, "_completed"}, done, 1'b1);
    e = sb.pop_front();
    check({tag, "_cycles"},   o.cyc,  e.cyc);
    check({tag, "_mem_req"},  o.memq, e.memq);
    check({tag, "_mem_wr"},   o.wrq,  e.wrq);
    check({tag, "_cc_we"},    o.cc,   e.cc);
    check({tag, "_rf_we_e"},  o.rfe,  e.rfe);
    check({tag, "_rf_we_m"},  o.rfm,  e.rfm);
    check({tag, "_enables"},  o.fe + o.de + o.ee + o.pcw, 4);
    check({tag, "_misplaced"}, o.bad, 0);
    retired_m++;
    cycles_m += e.cyc;
    check({tag, "_state"},   state,   3'd1);
    check({tag, "_retired"}, retired, retired_m);
    check({tag, "_cycles_cnt"}, cycles, cycles_m);
    check({tag, "_stat"},    stat,    3'd1);
  endtask

  task automatic expect_halt_ignores_start(input string tag);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check({tag, "_start_ignored"}, state, 3'd7);
    check({tag, "_strobes_off"},
          {fetch_en, decode_en, execute_en, mem_req, cc_we, rf_we_e, rf_we_m, pc_we}, 8'h00);
  endtask

  vec_t tbl[12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h3, 1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'h5, 1'b0, 3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'h2, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'h2, 1'b1, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'h6, 1'b0, 0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'h4, 1'b0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{4'h1, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'h7, 1'b1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'h8, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{4'h9, 1'b0, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{4'hA, 1'b0, 15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{4'hB, 1'b0, 2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state.
    do_reset();
    check("rst_state",   state,   3'd0);
    check("rst_stat",    stat,    3'd1);
    check("rst_halted",  halted,  1'b0);
    check("rst_retired", retired, 0);
    check("rst_cycles",  cycles,  0);
    check("rst_strobes",
          {fetch_en, decode_en, execute_en, mem_req, mem_wr, cc_we, rf_we_e, rf_we_m, pc_we}, 9'h000);

    // Table-driven instruction stream.
    go_fetch();
    for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("v%0d_i%0h", i, tbl[i].icode));

    // Memory timeout: mem_ready never rises.
    do_reset();
    go_fetch();
    begin
      int mem_cyc = 0;
      icode = 4'hA; instr_valid = 1'b1; mem_ready = 1'b0;
      for (int c = 0; c < 80 && state != 3'd7; c++) begin
        if (state == 3'd4) mem_cyc++;
        @(negedge clk);
      end
      check("tmo_mem_cycles", mem_cyc, 16);
    end
    check("tmo_state",   state,   3'd7);
    check("tmo_stat",    stat,    3'd3);
    check("tmo_halted",  halted,  1'b1);
    check("tmo_retired", retired, 0);
    expect_halt_ignores_start("tmo");

    // Data-memory fault on the first access.
    do_reset();
    go_fetch();
    icode = 4'h5; instr_valid = 1'b1;
    for (int c = 0; c < 10 && state != 3'd4; c++) @(negedge clk);
    mem_ready = 1'b1; dmem_error = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; dmem_error = 1'b0;
    check("dmem_state", state, 3'd7);
    check("dmem_stat",  stat,  3'd3);
    check("dmem_retired", retired, 0);

    // Fetch faults, in priority order.
    do_reset();
    go_fetch();
    imem_error = 1'b1; instr_valid = 1'b0; icode = 4'h0;
    @(negedge clk);
    imem_error = 1'b0;
    check("imem_state", state, 3'd7);
    check("imem_stat",  stat,  3'd3);
    check("imem_retired", retired, 0);
    expect_halt_ignores_start("imem");

    do_reset();
    go_fetch();
    instr_valid = 1'b0; icode = 4'h3;
    @(negedge clk);
    check("ins_state", state, 3'd7);
    check("ins_stat",  stat,  3'd4);
    check("ins_retired", retired, 0);
    expect_halt_ignores_start("ins");

    do_reset();
    go_fetch();
    instr_valid = 1'b1; icode = 4'h0;
    @(negedge clk);
    check("hlt_state", state, 3'd7);
    check("hlt_stat",  stat,  3'd2);
    check("hlt_retired", retired, 1);
    check("hlt_cycles",  cycles,  1);
    expect_halt_ignores_start("hlt");

    // Reset while waiting in MEMORY.
    do_reset();
    go_fetch();
    icode = 4'h4; instr_valid = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 10 && state != 3'd4; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("mid_mem_req_before", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_mem_wr",  mem_wr,  1'b0);
    check("mid_rst_state",   state,   3'd0);
    check("mid_rst_cycles",  cycles,  0);
    check("mid_rst_stat",    stat,    3'd1);
    @(negedge clk);
    rst_n = 1'b1;
    retired_m = 0;
    cycles_m  = 0;
    @(negedge clk);
    go_fetch();
    run_instr(tbl[1], "post_rst_i5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps fetch, decode, execute, memory, write-back and PC-update as separate clock states and drives the stage enables, register-file/condition-code/PC write strobes and the data-memory request. It holds a req/ready handshake with data memory under a timeout, and folds fetch and memory faults into the architectural status code. It sits beside the stage units and owns every state-changing strobe in the processor.

## Interface
- MEM_TIMEOUT, 15, max MEMORY-state cycles spent waiting for mem_ready (>=1)
- CNT_W, 32, width of retired/cycle counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution; honoured only in IDLE
- icode  in  4  instruction code from fetch unit
- instr_valid  in  1  fetch unit: icode legal
- imem_error  in  1  fetch unit: instruction address fault
- cnd  in  1  execute unit branch/move condition
- mem_ready  in  1  data memory: access complete this cycle
- dmem_error  in  1  data memory: address fault, qualified by mem_ready
- state  out  3  current state encoding
- fetch_en, decode_en, execute_en  out  1 each  stage enables
- mem_req  out  1  data-memory request, held until accepted
- mem_wr  out  1  request is a write (valid with mem_req)
- cc_we  out  1  condition-code write
- rf_we_e  out  1  register write of valE to dstE
- rf_we_m  out  1  register write of valM to dstM
- pc_we  out  1  PC register update
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- halted  out  1  in HALT state
- retired  out  CNT_W  instructions completed
- cycles  out  CNT_W  active cycles

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
- All outputs decode from registered state, latched ir_icode and latched cnd_q only; no combinational input-to-output path.
- IDLE: start=1 -> FETCH, stat<=AOK.
- FETCH: fetch_en=1. Priority: imem_error -> HALT, stat=ADR. Else !instr_valid -> HALT, stat=INS. Else icode=0 -> HALT, stat=HLT, retired+1. Else latch ir_icode<=icode -> DECODE.
- DECODE: decode_en=1 -> EXECUTE.
- EXECUTE: execute_en=1; cc_we=1 iff ir_icode=6; cnd_q<=cnd. Next is MEMORY iff ir_icode in {4,5,8,9,A,B}, else WRITEBACK.
- MEMORY: mem_req=1; mem_wr=1 iff ir_icode in {4,8,A}. mem_ready&dmem_error -> HALT, stat=ADR. mem_ready&!dmem_error -> WRITEBACK. !mem_ready with wait_cnt==MEM_TIMEOUT -> HALT, stat=ADR. Otherwise wait_cnt+1.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits and clears on every entry to MEMORY. mem_ready in the final allowed cycle wins over the timeout.
- WRITEBACK: rf_we_e=1 iff ir_icode in {3,6,8,9,A,B}, or ir_icode=2 and cnd_q=1. rf_we_m=1 iff ir_icode in {5,B}. Always -> PCUPD.
- PCUPD: pc_we=1, retired+1 -> FETCH.
- HALT: halted=1; all strobes 0; start ignored; exit only by reset.
- cycles increments every clock in states 1-6. Both counters wrap modulo 2^CNT_W silently.
- ir_icode values 1 (nop) and 7 (jXX) take the no-memory path with no register write.

## Timing
- Reset (async assert, sync-free deassert): state=IDLE, stat=AOK, halted=0, retired=0, cycles=0, ir_icode=0, cnd_q=0, wait_cnt=0. Every strobe and enable is 0 while rst_n=0.
- Reset asserted mid-instruction, including MEMORY with mem_req high: all outputs drop in the same instant, with no write strobe completing.
- Latency without memory: 5 cycles FETCH->PCUPD. With memory: 6 + N cycles, where N is the number of MEMORY cycles with mem_ready=0.
- Timeout: MEMORY occupied for exactly MEM_TIMEOUT+1 cycles, then HALT.
- Every strobe is exactly one cycle wide per instruction, except mem_req (held) and execute_en/decode_en/fetch_en (one cycle each).
- Faulting instruction: no pc_we, no register write, retired unchanged. Halt instruction increments retired.

## Test plan
- Reset, start pulse, icode=3 valid: states 1,2,3,5,6,1. rf_we_e=1 only in WRITEBACK, pc_we=1 only in PCUPD, retired=1, cycles=5 on the next FETCH.
- icode=5, mem_ready low 3 cycles then high: MEMORY lasts 4 cycles with mem_req=1, mem_wr=0. Then rf_we_m=1, rf_we_e=0, total 9 cycles.
- icode=2 with cnd=0 gives rf_we_e=0; with cnd=1 gives rf_we_e=1. icode=6 gives cc_we=1 in EXECUTE only; icode=4 gives mem_wr=1.
- icode=A, mem_ready never asserted, MEM_TIMEOUT=15: 16 MEMORY cycles, then HALT, stat=3, retired unchanged. Repeat with mem_ready in the 16th cycle -> WRITEBACK.
- FETCH faults: imem_error=1 with instr_valid=0 -> stat=3. instr_valid=0 alone -> stat=4. icode=0 -> stat=2 and retired+1. In all cases start is ignored afterwards.
- rst_n low for 1 cycle during MEMORY wait: mem_req, state, counters and stat return to reset values immediately. A later start executes cleanly.
